// File: rtl/pack_build_if.sv
// Trace-to-packet-buffer bus for pack_build.
//   TraceWd/TraceWdAvail : halfword stream from the trace front end
//   sync                 : frame alignment established
//   WdAvail/PacketWd     : frame word strobe and data toward the packet buffer
//   PacketCommit         : the last 8 words form a complete frame
//   PacketReset          : discard uncommitted words
// master = front end / buffer side, slave = pack_build.
interface pack_build_if;
  localparam int unsigned WordW = 16;

  logic [WordW-1:0] TraceWd;
  logic             TraceWdAvail;
  logic             sync;
  logic             WdAvail;
  logic [WordW-1:0] PacketWd;
  logic             PacketCommit;
  logic             PacketReset;

  modport master (
    output TraceWd, TraceWdAvail,
    input  sync, WdAvail, PacketWd, PacketCommit, PacketReset
  );

  modport slave (
    input  TraceWd, TraceWdAvail,
    output sync, WdAvail, PacketWd, PacketCommit, PacketReset
  );
endinterface

// File: rtl/pack_build.sv
// Packet assembler on the trace write clock. Finds TPIU full sync
// (FFFF followed by 7FFF), strips sync and idle halfwords, and groups data
// halfwords into 8-word frames for the downstream packet buffer.
// Ports:
//   wrClk : clock
//   rst   : synchronous active-high reset
//   bus   : pack_build_if.slave (trace input, packet buffer handshake, sync)
// Parameter SYNC_TIMEOUT_LOG2: sync is dropped after 2^SYNC_TIMEOUT_LOG2
// cycles without a full sync.
module pack_build #(
  parameter int unsigned SYNC_TIMEOUT_LOG2 = 24
) (
  input  logic        wrClk,
  input  logic        rst,
  pack_build_if.slave bus
);
  localparam int unsigned WordW  = 16;
  localparam int unsigned WcW    = 3;
  localparam int unsigned TimerW = SYNC_TIMEOUT_LOG2;
  localparam logic [WordW-1:0] SyncHi = 16'hFFFF;
  localparam logic [WordW-1:0] SyncLo = 16'h7FFF;

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } syncState_t;

  syncState_t        state, stateNxt;
  logic [WordW-1:0]  held, heldNxt;
  logic              heldV, heldVNxt;
  logic [WcW-1:0]    wc, wcNxt;
  logic              commitPend, commitPendNxt;
  logic [TimerW-1:0] timer, timerNxt;
  logic              wdAvail, wdAvailNxt;
  logic [WordW-1:0]  packetWd, packetWdNxt;
  logic              packetCommit, packetCommitNxt;
  logic              packetReset, packetResetNxt;
  logic              fullSync;
  logic              timeout;
  logic              emit;

  // State and output registers
  always_ff @(posedge wrClk) begin
    if (rst) begin
      state        <= UNSYNCED;
      held         <= '0;
      heldV        <= 1'b0;
      wc           <= '0;
      commitPend   <= 1'b0;
      timer        <= '0;
      wdAvail      <= 1'b0;
      packetWd     <= '0;
      packetCommit <= 1'b0;
      packetReset  <= 1'b0;
    end else begin
      state        <= stateNxt;
      held         <= heldNxt;
      heldV        <= heldVNxt;
      wc           <= wcNxt;
      commitPend   <= commitPendNxt;
      timer        <= timerNxt;
      wdAvail      <= wdAvailNxt;
      packetWd     <= packetWdNxt;
      packetCommit <= packetCommitNxt;
      packetReset  <= packetResetNxt;
    end
  end

  // Input classification, sync FSM, framing and strobes
  always_comb begin
    stateNxt        = state;
    heldNxt         = held;
    heldVNxt        = heldV;
    wcNxt           = wc;
    commitPendNxt   = 1'b0;
    timerNxt        = timer;
    wdAvailNxt      = 1'b0;
    packetWdNxt     = packetWd;
    packetCommitNxt = 1'b0;
    packetResetNxt  = 1'b0;
    emit            = 1'b0;

    fullSync = bus.TraceWdAvail && heldV && (held == SyncHi) && (bus.TraceWd == SyncLo);
    timeout  = (state == SYNCED) && (&timer);

    // Timer saturates at all-ones so a timeout deferred by a commit still fires next cycle
    if ((state == SYNCED) && !timeout) begin
      timerNxt = timer + TimerW'(1);
    end

    if (commitPend) begin
      packetCommitNxt = 1'b1;
    end

    if (fullSync) begin
      stateNxt       = SYNCED;
      heldVNxt       = 1'b0;
      wcNxt          = '0;
      timerNxt       = '0;
      packetResetNxt = 1'b1;
    end else if (timeout && !commitPend) begin
      stateNxt       = UNSYNCED;
      heldVNxt       = 1'b0;
      wcNxt          = '0;
      timerNxt       = '0;
      packetResetNxt = (wc != '0);
    end else if (bus.TraceWdAvail) begin
      // Any non-sync arrival pushes out the held word; 7FFF itself is dropped
      emit = heldV;
      if (bus.TraceWd == SyncLo) begin
        heldVNxt = 1'b0;
      end else begin
        heldNxt  = bus.TraceWd;
        heldVNxt = 1'b1;
      end
    end

    // Words emitted while unsynced are dropped and wc stays 0
    if (emit && (state == SYNCED)) begin
      wdAvailNxt  = 1'b1;
      packetWdNxt = held;
      wcNxt       = wc + WcW'(1);
      if (wc == '1) begin
        commitPendNxt = 1'b1;
      end
    end
  end

  assign bus.sync         = (state == SYNCED);
  assign bus.WdAvail      = wdAvail;
  assign bus.PacketWd     = packetWd;
  assign bus.PacketCommit = packetCommit;
  assign bus.PacketReset  = packetReset;
endmodule

// File: tb/tb_pack_build.sv
// Self-checking bench for pack_build. Stimulus pushes expected strobe events
// and expected per-cycle output levels into queues; a single monitor on the
// falling clock edge pops and compares them against the DUT outputs.
module tb_pack_build;
  localparam int unsigned TimeoutLog2 = 6;
  localparam int KindWord   = 0;
  localparam int KindCommit = 1;
  localparam int KindReset  = 2;
  localparam int SelSync     = 0;
  localparam int SelWdAvail  = 1;
  localparam int SelPacketWd = 2;
  localparam int SelCommit   = 3;
  localparam int SelReset    = 4;
  localparam int CycleLimit  = 4000;

  typedef struct {
    int          kind;
    logic [15:0] data;
    logic        syncV;
  } ev_t;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] val;
  } lvl_t;

  logic wrClk  = 1'b0;
  logic rst    = 1'b1;
  int   cyc    = 0;
  bit   done   = 1'b0;
  int   nVec   = 0;
  int   nErr   = 0;
  logic prevWd = 1'b0;
  ev_t  expQ[$];
  lvl_t lvlQ[$];

  pack_build_if bus();

  pack_build #(.SYNC_TIMEOUT_LOG2(TimeoutLog2)) dut (
    .wrClk(wrClk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 wrClk = ~wrClk;

  always @(posedge wrClk) cyc <= cyc + 1;

  // ---------------- stimulus helpers ----------------
  task automatic expEv(input int k, input logic [15:0] d, input logic s);
    ev_t e;
    e.kind  = k;
    e.data  = d;
    e.syncV = s;
    expQ.push_back(e);
  endtask

  task automatic expWord(input logic [15:0] d);
    expEv(KindWord, d, 1'b1);
  endtask

  task automatic expLevel(input int sel, input logic [15:0] v);
    lvl_t l;
    l.cyc = cyc;
    l.sel = sel;
    l.val = v;
    lvlQ.push_back(l);
  endtask

  task automatic drive(input logic [15:0] w);
    bus.TraceWd      = w;
    bus.TraceWdAvail = 1'b1;
    @(posedge wrClk);
    #1;
    bus.TraceWdAvail = 1'b0;
  endtask

  task automatic gap();
    @(posedge wrClk);
    #1;
  endtask

  task automatic sendWord(input logic [15:0] w);
    drive(w);
    gap();
  endtask

  task automatic idle(input int n);
    repeat (n) gap();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bus.TraceWd      = '0;
    bus.TraceWdAvail = 1'b0;
    rst              = 1'b1;
    repeat (3) @(posedge wrClk);
    #1;
    rst = 1'b0;
    expLevel(SelSync, 16'h0000);
    expLevel(SelWdAvail, 16'h0000);
    expLevel(SelPacketWd, 16'h0000);
    expLevel(SelCommit, 16'h0000);
    expLevel(SelReset, 16'h0000);
    gap();

    // Sync acquisition
    sendWord(16'hFFFF);
    expLevel(SelSync, 16'h0000);
    expLevel(SelWdAvail, 16'h0000);
    expEv(KindReset, 16'h0000, 1'b1);
    drive(16'h7FFF);
    expLevel(SelSync, 16'h0001);
    expLevel(SelReset, 16'h0001);
    expLevel(SelWdAvail, 16'h0000);
    gap();
    expLevel(SelReset, 16'h0000);

    // Full frame
    for (int i = 1; i <= 8; i++) expWord(16'(i));
    expEv(KindCommit, 16'h0000, 1'b1);
    for (int i = 1; i <= 8; i++) sendWord(16'(i));
    drive(16'h7FFF);
    expLevel(SelWdAvail, 16'h0001);
    expLevel(SelPacketWd, 16'h0008);
    gap();
    expLevel(SelCommit, 16'h0001);
    expLevel(SelWdAvail, 16'h0000);
    expLevel(SelPacketWd, 16'h0008);
    idle(2);

    // Partial frame discarded by resync, next frame commits
    expWord(16'h0011);
    expWord(16'h0012);
    expWord(16'h0013);
    expEv(KindReset, 16'h0000, 1'b1);
    sendWord(16'h0011);
    sendWord(16'h0012);
    sendWord(16'h0013);
    drive(16'hFFFF);
    expLevel(SelPacketWd, 16'h0013);
    gap();
    drive(16'h7FFF);
    expLevel(SelReset, 16'h0001);
    expLevel(SelSync, 16'h0001);
    gap();
    expLevel(SelCommit, 16'h0000);
    for (int i = 1; i <= 8; i++) expWord(16'h0020 + 16'(i));
    expEv(KindCommit, 16'h0000, 1'b1);
    for (int i = 1; i <= 8; i++) sendWord(16'h0020 + 16'(i));
    sendWord(16'h7FFF);
    idle(2);

    // FFFF as data
    expWord(16'hFFFF);
    expWord(16'h1234);
    sendWord(16'hFFFF);
    sendWord(16'h1234);
    drive(16'h7FFF);
    expLevel(SelPacketWd, 16'h1234);
    expLevel(SelReset, 16'h0000);
    expLevel(SelSync, 16'h0001);
    gap();
    idle(2);

    // Sync loss after 2^6 cycles with wc=2
    expEv(KindReset, 16'h0000, 1'b1);
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    k = cyc;
    expWord(16'h0051);
    expWord(16'h0052);
    expEv(KindReset, 16'h0000, 1'b0);
    sendWord(16'h0051);
    sendWord(16'h0052);
    sendWord(16'h7FFF);
    repeat (k + 62 - cyc) @(posedge wrClk);
    #1;
    expLevel(SelSync, 16'h0001);
    gap();
    expLevel(SelSync, 16'h0000);
    expLevel(SelReset, 16'h0001);
    sendWord(16'h0061);
    sendWord(16'h0062);
    sendWord(16'h7FFF);
    expLevel(SelSync, 16'h0000);
    idle(2);

    // Reset mid-frame, then resync and a clean frame
    expEv(KindReset, 16'h0000, 1'b1);
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    for (int i = 1; i <= 5; i++) expWord(16'h0070 + 16'(i));
    for (int i = 1; i <= 6; i++) sendWord(16'h0070 + 16'(i));
    rst = 1'b1;
    @(posedge wrClk);
    #1;
    rst = 1'b0;
    expLevel(SelSync, 16'h0000);
    expLevel(SelWdAvail, 16'h0000);
    expLevel(SelPacketWd, 16'h0000);
    expLevel(SelCommit, 16'h0000);
    expLevel(SelReset, 16'h0000);
    gap();
    expEv(KindReset, 16'h0000, 1'b1);
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    for (int i = 1; i <= 8; i++) expWord(16'h0080 + 16'(i));
    expEv(KindCommit, 16'h0000, 1'b1);
    for (int i = 1; i <= 8; i++) sendWord(16'h0080 + 16'(i));
    sendWord(16'h7FFF);
    idle(3);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  function automatic logic [15:0] levelOf(input int sel);
    case (sel)
      SelSync:     return 16'(bus.sync);
      SelWdAvail:  return 16'(bus.WdAvail);
      SelPacketWd: return bus.PacketWd;
      SelCommit:   return 16'(bus.PacketCommit);
      SelReset:    return 16'(bus.PacketReset);
      default:     return 16'hDEAD;
    endcase
  endfunction

  function automatic string selName(input int sel);
    case (sel)
      SelSync:     return "sync";
      SelWdAvail:  return "WdAvail";
      SelPacketWd: return "PacketWd";
      SelCommit:   return "PacketCommit";
      SelReset:    return "PacketReset";
      default:     return "unknown";
    endcase
  endfunction

  always @(negedge wrClk) begin
    int   nStb;
    int   actKind;
    logic ok;
    ev_t  e;
    lvl_t l;

    while (lvlQ.size() != 0 && lvlQ[0].cyc <= cyc) begin
      l = lvlQ.pop_front();
      nVec++;
      if (l.cyc != cyc || levelOf(l.sel) !== l.val) begin
        nErr++;
        $display("FAIL level_%s cycle %0d: got %h, expected %h (scheduled cycle %0d)",
                 selName(l.sel), cyc, levelOf(l.sel), l.val, l.cyc);
      end
    end

    nStb = int'(bus.WdAvail) + int'(bus.PacketCommit) + int'(bus.PacketReset);
    if (nStb > 1) begin
      nVec++;
      nErr++;
      $display("FAIL strobe_overlap cycle %0d: WdAvail=%b PacketCommit=%b PacketReset=%b, expected at most one",
               cyc, bus.WdAvail, bus.PacketCommit, bus.PacketReset);
    end

    if (bus.PacketCommit) begin
      nVec++;
      if (prevWd !== 1'b1) begin
        nErr++;
        $display("FAIL commit_spacing cycle %0d: previous WdAvail=%b, expected 1", cyc, prevWd);
      end
    end

    if (nStb != 0) begin
      actKind = bus.WdAvail ? KindWord : (bus.PacketCommit ? KindCommit : KindReset);
      nVec++;
      if (expQ.size() == 0) begin
        nErr++;
        $display("FAIL unexpected_strobe cycle %0d: got kind %0d data %h, expected none",
                 cyc, actKind, bus.PacketWd);
      end else begin
        e  = expQ.pop_front();
        ok = (e.kind == actKind) && (e.syncV === bus.sync) &&
             ((actKind != KindWord) || (e.data === bus.PacketWd));
        if (!ok) begin
          nErr++;
          $display("FAIL strobe_event cycle %0d: got kind %0d data %h sync %b, expected kind %0d data %h sync %b",
                   cyc, actKind, bus.PacketWd, bus.sync, e.kind, e.data, e.syncV);
        end
      end
    end
    prevWd = bus.WdAvail;

    if (done || cyc > CycleLimit) begin
      if (!done) begin
        nVec++;
        nErr++;
        $display("FAIL watchdog cycle %0d: stimulus still running, expected done", cyc);
      end
      nVec++;
      if (expQ.size() != 0 || lvlQ.size() != 0) begin
        nErr++;
        $display("FAIL leftover_expectations: got %0d events and %0d levels pending, expected 0 and 0",
                 expQ.size(), lvlQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
    end
  end
endmodule

// File: doc/pack_build.md
# pack_build

Packet assembler on the trace write clock: takes 16-bit halfwords from the trace front end, finds TPIU full-sync, strips sync and idle padding, and groups data halfwords into fixed 8-word frames. It drives the word/commit/reset handshake of the downstream packet buffer, which only forwards committed frames to the host link. It also drives the `sync` indication used by that buffer to decide when to re-insert sync bytes toward the host.

## Interface
- `SYNC_TIMEOUT_LOG2`, default 24: width of the sync-loss timer. Sync is dropped after 2^SYNC_TIMEOUT_LOG2 wrClk cycles with no full sync.
- `wrClk`  in  1  clock; all logic is in this domain.
- `rst`  in  1  reset, synchronous, active-high.
- `TraceWd`  in  16  halfword from the front end; bits [7:0] are the earlier byte.
- `TraceWdAvail`  in  1  `TraceWd` valid this cycle. The front end never asserts it on two consecutive cycles.
- `sync`  out  1  frame alignment established.
- `WdAvail`  out  1  one-cycle strobe: `PacketWd` holds a frame word.
- `PacketWd`  out  16  frame word.
- `PacketCommit`  out  1  one-cycle strobe: the 8 words just written form a complete frame.
- `PacketReset`  out  1  one-cycle strobe: discard uncommitted words.

## Operation
- Internal state:
  - held word `H` with valid flag `Hv`;
  - 3-bit word counter `wc`;
  - commit-pending flag;
  - sync timer, SYNC_TIMEOUT_LOG2 bits.
- Each accepted input word `W` is classified in priority order:
  1. **Full sync.** `Hv && H==16'hFFFF && W==16'h7FFF`. Discard both words, `Hv<=0`, `sync<=1`, `wc<=0`, timer<=0, pulse `PacketReset`.
  2. **Halfword sync / idle.** `W==16'h7FFF` otherwise. Discard `W`. If `Hv`, emit `H`. Set `Hv<=0`.
  3. **Data.** If `Hv`, emit `H`. Then `H<=W`, `Hv<=1`.
- A data word 16'hFFFF is only ever held, never treated as sync by itself.
- Emit, when `sync==1`:
  - `PacketWd<=H`, `WdAvail<=1`, `wc<=wc+1`.
  - When the emitted word is the 8th (`wc==7`), `wc` wraps to 0 and commit-pending is set.
  - The cycle after that 8th word, `PacketCommit<=1`.
- Emit, when `sync==0`: the word is dropped and `wc` stays 0.
- Sync FSM, two states:
  - UNSYNCED → SYNCED on full sync.
  - SYNCED → SYNCED on full sync: timer restart; partial frame discarded via `PacketReset`.
  - SYNCED → UNSYNCED when the timer reaches all-ones: `sync<=0`, `Hv<=0`, `wc<=0`, and `PacketReset` is pulsed if `wc!=0`.
- The timer counts every cycle while SYNCED and is held at 0 while UNSYNCED.
- Exclusivity: `WdAvail`, `PacketCommit` and `PacketReset` are never high in the same cycle. The input spacing rule guarantees commit never collides with an emit or a full-sync reset.
- Timeout colliding with commit-pending: `PacketCommit` is issued that cycle, so the completed frame is kept. The sync loss, with `wc` now 0, takes effect the next cycle, and no `PacketReset` is issued.
- `rst` mid-frame: all state is cleared and no strobe is issued. Downstream is reset by the same `rst`.

## Timing
- Reset values: `sync=0`, `WdAvail=0`, `PacketWd=16'h0000`, `PacketCommit=0`, `PacketReset=0`, `Hv=0`, `wc=0`, timer=0, commit-pending=0.
- `TraceWdAvail` high in cycle t produces its effect (emit, `sync`, `PacketReset`) registered at the end of t, visible in cycle t+1.
- `PacketCommit` is visible in the cycle after the 8th `WdAvail`, i.e. cycle t+2 relative to the input that pushed the 8th word.
- Latency of a data word: it is emitted when the next data word or a 7FFF arrives, never on its own.
- `PacketWd` holds its value between strobes.
- All strobes last exactly 1 cycle.
- Timeout: `sync` falls 2^SYNC_TIMEOUT_LOG2 cycles after the cycle in which the last full sync was registered.

## Test plan
1. **Sync acquisition.** After `rst`, input FFFF, 7FFF (2-cycle spacing) → `sync` rises with a single `PacketReset` pulse in the same cycle; no `WdAvail`.
2. **Full frame.** Synced; input 0x0001..0x0008 then 0x7FFF → 8 `WdAvail` pulses carrying 0x0001..0x0008, the 8th one cycle after the 7FFF input; `PacketCommit` exactly one cycle after the 8th pulse; never overlapping `WdAvail`.
3. **Partial frame discarded.** Synced; input 3 data words, then FFFF, 7FFF → `PacketWd` 1..2 emitted, word 3 emitted by FFFF arrival; then `PacketReset`, no `PacketCommit`; next 8 words commit normally with `wc` restarted.
4. **FFFF as data.** Synced; input FFFF, 0x1234, 0x7FFF → `PacketWd`=0xFFFF then 0x1234 emitted, `sync` stays 1, no `PacketReset`.
5. **Sync loss.** `SYNC_TIMEOUT_LOG2=6`; sync, 2 data words + 7FFF, then idle → `sync` falls 64 cycles after sync with `PacketReset` (`wc`=2); subsequent data produces no `WdAvail`.
6. **Reset mid-frame.** Assert `rst` after 5 emitted words → all outputs return to reset values next cycle; after re-sync, the first `PacketCommit` follows exactly 8 new words.
